// File: rtl/fifo_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : fifo_arb_pkg
// Brief    : Shared types and helpers for the FIFO write-port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int c_MAX_NREQ = 16;

    function automatic int ptr_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Callers trim the result to their own requester count.
    function automatic logic [c_MAX_NREQ-1:0] idx_to_onehot(input logic [3:0] idx);
        logic [c_MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_arb_pick
// Brief    : Combinational rotate-priority picker; first valid index after ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    localparam logic [PW-1:0] c_LAST = PW'(NREQ - 1);

    logic [PW-1:0] w_cand;

    // Walk ptr+1 .. ptr+NREQ with wrap; the last candidate is ptr itself.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (w_cand == c_LAST) ? '0 : w_cand + 1'b1;
            if (!o_any && i_valid[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, packet-locked arbiter sharing the async FIFO write port.
//            Optional per-requester grant counters via FIFO_ARB_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int CNTW     = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NREQ-1:0]          REQ_VALID_I,
    input  logic [NREQ-1:0]          REQ_LAST_I,
    input  logic [NREQ*DATASIZE-1:0] REQ_DATA_I,
    output logic [NREQ-1:0]          REQ_READY_O,
    output logic [NREQ-1:0]          GNT_O,
    output logic                     BUSY_O,
    output logic [DATASIZE-1:0]      WDATA_O,
`ifdef FIFO_ARB_STATS_EN
    output logic [NREQ*CNTW-1:0]     GNT_CNT_O,
    input  logic                     CNT_CLR_I,
`endif
    output logic                     WINC_O,
    input  logic                     WFULL_I
);

    localparam int c_PW = ptr_width(NREQ);

    generate
        if (NREQ < 2 || NREQ > c_MAX_NREQ || CNTW < 1) begin : g_param_check
            $error("fifo_wr_arbiter: NREQ must be 2..16 and CNTW >= 1");
        end
    endgenerate

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [NREQ-1:0]     r_gnt;
    logic [c_PW-1:0]     r_ptr;
    logic                r_out_valid;
    logic [DATASIZE-1:0] r_out_data;

    logic [c_PW-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic [NREQ-1:0]     w_pick_oh;
    logic                w_grant_evt;
    logic                w_hs;
    logic                w_hs_last;
    logic [DATASIZE-1:0] w_sel_data;

    rr_arb_pick #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_pick (
        .i_valid (REQ_VALID_I),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_pick_oh   = NREQ'(idx_to_onehot(4'(w_pick_idx)));
    assign w_grant_evt = (r_state == ARB_IDLE) && w_pick_any;
    assign w_hs        = |(REQ_VALID_I & REQ_READY_O);
    assign w_hs_last   = |(REQ_VALID_I & REQ_LAST_I & REQ_READY_O);

    // r_gnt is one-hot while locked, so an OR of masked lanes is the mux.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_sel_data = w_sel_data | REQ_DATA_I[i*DATASIZE +: DATASIZE];
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_any) w_state_nxt = ARB_LOCK;
            ARB_LOCK: if (w_hs_last)  w_state_nxt = ARB_IDLE;
            default:                  w_state_nxt = ARB_IDLE;
        endcase
    end

    // A beat may enter only if the output register is empty or draining now.
    always_comb begin
        REQ_READY_O = '0;
        if (r_state == ARB_LOCK && (!r_out_valid || !WFULL_I)) begin
            REQ_READY_O = r_gnt;
        end
        BUSY_O = (r_state == ARB_LOCK) || r_out_valid;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_gnt       <= '0;
            r_ptr       <= c_PW'(NREQ - 1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_grant_evt) begin
                r_gnt <= w_pick_oh;
                r_ptr <= w_pick_idx;
            end else if (w_hs_last) begin
                r_gnt <= '0;
            end
            if (w_hs) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
            end else if (r_out_valid && !WFULL_I) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign GNT_O   = r_gnt;
    assign WINC_O  = r_out_valid;
    assign WDATA_O = r_out_data;

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
            logic [CNTW-1:0] r_cnt;
            always_ff @(posedge CLK_I or posedge RST_I) begin
                if (RST_I) begin
                    r_cnt <= '0;
                end else if (CNT_CLR_I) begin
                    r_cnt <= '0;
                end else if (w_grant_evt && w_pick_oh[gi] && !(&r_cnt)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign GNT_CNT_O[gi*CNTW +: CNTW] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for fifo_wr_arbiter (FIFO_ARB_STATS_EN optional).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int CNTW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_last, req_ready, gnt;
    logic [NREQ*DW-1:0]   req_data;
    logic                 busy, winc, wfull;
    logic [DW-1:0]        wdata;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*CNTW-1:0] gnt_cnt;
    logic                 cnt_clr;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .CNTW(CNTW)) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .REQ_VALID_I (req_valid),
        .REQ_LAST_I  (req_last),
        .REQ_DATA_I  (req_data),
        .REQ_READY_O (req_ready),
        .GNT_O       (gnt),
        .BUSY_O      (busy),
        .WDATA_O     (wdata),
`ifdef FIFO_ARB_STATS_EN
        .GNT_CNT_O   (gnt_cnt),
        .CNT_CLR_I   (cnt_clr),
`endif
        .WINC_O      (winc),
        .WFULL_I     (wfull)
    );

    typedef struct packed {
        logic          hole;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t           rq[NREQ][$];
    logic [DW-1:0]   exp_data_q[$];
    logic [NREQ-1:0] exp_gnt_q[$];
    int              stamp_q[$];
    logic [NREQ-1:0] hs_rec;
    logic [NREQ-1:0] prev_gnt;
    logic [DW-1:0]   exp_d;
    logic [NREQ-1:0] exp_g;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Requester models: present the queue head, pop it after an accepted beat.
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        hs_rec    = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (hs_rec[i] && rq[i].size() > 0) rq[i].delete(0);
                if (rq[i].size() > 0 && rq[i][0].hole) begin
                    rq[i].delete(0);
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end else if (rq[i].size() > 0) begin
                    req_valid[i]           = 1'b1;
                    req_last[i]            = rq[i][0].last;
                    req_data[i*DW +: DW]   = rq[i][0].data;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            #4;
            hs_rec = req_valid & req_ready;
        end
    end

    // Monitor: every consumed write beat and every new grant against the scoreboard.
    initial begin
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            #4;
            if (winc && !wfull) begin
                stamp_q.push_back(cyc);
                n_tests++;
                if (exp_data_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wdata_unexpected: got %02h, required no beat", wdata);
                end else begin
                    exp_d = exp_data_q.pop_front();
                    if (wdata !== exp_d) begin
                        n_fail++;
                        $display("FAIL wdata_order: got %02h, required %02h", wdata, exp_d);
                    end
                end
            end
            if (gnt != '0 && gnt != prev_gnt) begin
                n_tests++;
                if (exp_gnt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL gnt_unexpected: got %b, required no grant", gnt);
                end else begin
                    exp_g = exp_gnt_q.pop_front();
                    if (gnt !== exp_g) begin
                        n_fail++;
                        $display("FAIL gnt_order: got %b, required %b", gnt, exp_g);
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.hole = 1'b0;
        b.last = l;
        b.data = d;
        rq[r].push_back(b);
    endtask

    task automatic push_hole(input int r);
        beat_t b;
        b = '0;
        b.hole = 1'b1;
        rq[r].push_back(b);
    endtask

    function automatic bit reqs_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 300 && !(reqs_empty() && !busy && exp_data_q.size() == 0)) begin
            @(negedge clk);
            #2;
            k++;
        end
        check({name, "_drain"}, (k < 300) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        #2;
        check({name, "_gnt_left"}, exp_gnt_q.size(), 0);
        check({name, "_data_left"}, exp_data_q.size(), 0);
    endtask

    task automatic check_gaps(input string name, input int n, input int gaps[$]);
        check({name, "_beats"}, stamp_q.size(), n);
        if (stamp_q.size() == n) begin
            for (int i = 0; i < n - 1; i++) begin
                check({name, "_spacing"}, stamp_q[i+1] - stamp_q[i], gaps[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        wfull = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #2;
        check("rst_gnt",   gnt,       0);
        check("rst_ready", req_ready, 0);
        check("rst_winc",  winc,      0);
        check("rst_wdata", wdata,     0);
        check("rst_busy",  busy,      0);
        rst = 1'b0;

        // Two 3-beat packets: req0 first, one bubble when the grant moves to req2.
        stamp_q.delete();
        push_beat(0, 8'hA0, 1'b0); push_beat(0, 8'hA1, 1'b0); push_beat(0, 8'hA2, 1'b1);
        push_beat(2, 8'hC0, 1'b0); push_beat(2, 8'hC1, 1'b0); push_beat(2, 8'hC2, 1'b1);
        exp_gnt_q  = '{4'b0001, 4'b0100};
        exp_data_q = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
        wait_idle("ac");
        check_gaps("ac", 6, '{1, 1, 2, 1, 1});

        // Reset mid-packet with a beat held in the output register.
        wfull = 1'b1;
        push_beat(1, 8'h21, 1'b0); push_beat(1, 8'h22, 1'b0); push_beat(1, 8'h23, 1'b1);
        exp_gnt_q = '{4'b0010};
        repeat (4) @(negedge clk);
        #2;
        check("mr_busy_before", busy, 1);
        check("mr_winc_before", winc, 1);
        rst = 1'b1;
        #1;
        check("mr_gnt",   gnt,       0);
        check("mr_ready", req_ready, 0);
        check("mr_winc",  winc,      0);
        check("mr_wdata", wdata,     0);
        check("mr_busy",  busy,      0);
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        hs_rec = '0;
        repeat (2) @(negedge clk);
        #2;
        rst   = 1'b0;
        wfull = 1'b0;

        // Single-beat packets on all requesters: grant restarts at req0 after reset.
        stamp_q.delete();
        push_beat(0, 8'h10, 1'b1); push_beat(0, 8'h14, 1'b1);
        push_beat(1, 8'h11, 1'b1);
        push_beat(2, 8'h12, 1'b1);
        push_beat(3, 8'h13, 1'b1);
        exp_gnt_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_data_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        wait_idle("rr");
        check_gaps("rr", 5, '{2, 2, 2, 2});

        // Full for five clocks: beat 0x31 is parked in the output register.
        for (int i = 0; i < 6; i++) push_beat(3, 8'(8'h30 + i), (i == 5));
        exp_gnt_q  = '{4'b1000};
        exp_data_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        repeat (4) @(negedge clk);
        #2;
        wfull = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #3;
            end
            check("full_wdata", wdata,     8'h31);
            check("full_winc",  winc,      1);
            check("full_ready", req_ready, 0);
        end
        @(negedge clk);
        #2;
        wfull = 1'b0;
        wait_idle("full");

        // Req1 idles three clocks mid-packet while req3 waits: lock must hold.
        push_beat(1, 8'h50, 1'b0); push_beat(1, 8'h51, 1'b0);
        push_hole(1); push_hole(1); push_hole(1);
        push_beat(1, 8'h52, 1'b0); push_beat(1, 8'h53, 1'b1);
        push_beat(3, 8'h60, 1'b1);
        exp_gnt_q  = '{4'b0010, 4'b1000};
        exp_data_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60};
        repeat (6) @(negedge clk);
        #2;
        check("lock_valid1_low", req_valid[1], 0);
        check("lock_gnt",        gnt,          4'b0010);
        check("lock_ready3",     req_ready[3], 0);
        wait_idle("lock");

`ifdef FIFO_ARB_STATS_EN
        // Grants since the mid-run reset: req0 x2, req1 x2, req2 x1, req3 x3.
        check("cnt0", gnt_cnt[0*CNTW +: CNTW], 2);
        check("cnt1", gnt_cnt[1*CNTW +: CNTW], 2);
        check("cnt2", gnt_cnt[2*CNTW +: CNTW], 1);
        check("cnt3", gnt_cnt[3*CNTW +: CNTW], 3);
        cnt_clr = 1'b1;
        @(negedge clk);
        #2;
        cnt_clr = 1'b0;
        check("cnt_clr", gnt_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
